dual_blocking_out_gen: RTL
==========================

Name: dual_blocking_out_gen

Overview:
- Parametrised generator with two blocking output channels, each using the sync/notify handshake: an unsigned channel (u_out) and a signed channel (s_out).
- Internal section state machine emits a running unsigned value and a running signed value, updated by fixed steps after every completed transfer.
- Supports alternating mode (A then B) or parallel mode (both channels offered together), plus wrap or saturate arithmetic on the signed path.
- Sits as a stimulus/producer block feeding downstream blocking consumers.

Parameters:
- DATA_W, 32, width of both data channels.
- U_INIT, 13, reset value of unsigned accumulator.
- S_INIT, -7, reset value of signed accumulator (DATA_W-bit two's complement).
- U_STEP, 3, unsigned increment after each u transfer, modulo 2^DATA_W.
- S_STEP, -2, signed increment after each s transfer.
- S_SAT, 0, 0 = signed wraps; 1 = signed clamps at min/max.
- PAR_MODE, 0, 0 = alternate sections; 1 = both channels offered simultaneously.
- CNT_W, 16, width of the round counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- u_out  output  DATA_W  unsigned data, stable while u_out_notify=1.
- u_out_sync  input  1  consumer ready for u_out.
- u_out_notify  output  1  u_out valid / write pending.
- s_out  output  DATA_W (signed)  signed data, stable while s_out_notify=1.
- s_out_sync  input  1  consumer ready for s_out.
- s_out_notify  output  1  s_out valid / write pending.
- section_o  output  2  current section: 0 = SEC_A, 1 = SEC_B, 2 = SEC_AB.
- round_cnt  output  CNT_W  completed rounds, wraps at 2^CNT_W.

Behaviour:
- Transfer on a channel = rising edge with notify=1 and sync=1. sync while notify=0 is ignored. notify never drops without a transfer.
- Reset, PAR_MODE=0 (asynchronous):
  - section SEC_A; u_acc=U_INIT, s_acc=S_INIT.
  - u_out=U_INIT, u_out_notify=1.
  - s_out=0, s_out_notify=0.
  - round_cnt=0.
- Reset, PAR_MODE=1: section SEC_AB; u_out=U_INIT, s_out=S_INIT, both notify=1; other outputs as above.
- Alternate mode FSM:
  - SEC_A with u transfer: u_out_notify<=0; u_acc<=u_acc+U_STEP; s_out<=s_acc; s_out_notify<=1; go to SEC_B. Same edge, no bubble.
  - SEC_B with s transfer: s_out_notify<=0; s_acc<=s_acc+S_STEP; u_out<=updated u_acc; u_out_notify<=1; round_cnt+1; go to SEC_A.
  - A one-transfer-per-cycle ping-pong is therefore possible when sync is held high.
- Parallel mode (SEC_AB only):
  - Each channel completes independently. On its transfer, that notify drops, its accumulator steps, and a done flag is set.
  - When the second channel completes (or both complete on the same edge), both notify reassert on that edge with the stepped values, done flags clear, and round_cnt+1.
  - A channel that already transferred keeps notify=0 until the other completes.
- Arithmetic:
  - u_acc wraps modulo 2^DATA_W.
  - s_acc with S_SAT=0 wraps in two's complement.
  - s_acc with S_SAT=1 computes the sum at DATA_W+1 bits and clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Data stability: u_out/s_out change only on the edge that raises the corresponding notify.
- Reset mid-operation: any pending transfer is abandoned and all state returns to reset values immediately. No transfer is counted for an edge coinciding with rst=1.

Test Plan:
- Reset, alternate mode → u_out=13, u_out_notify=1, s_out_notify=0, section_o=0, round_cnt=0.
- Hold both syncs high for 4 cycles, alternate mode → sequence u=13, s=-7, u=16, s=-9. notify ping-pongs each cycle; round_cnt=2.
- u_out_sync low for 5 cycles, then pulse → u_out stays 13 with notify=1 throughout. s_out_notify rises only after the pulse. s_out_sync pulses while s_out_notify=0 have no effect.
- PAR_MODE=1: s_out_sync at cycle 2, u_out_sync at cycle 5 → s_out_notify low cycles 3–5. Both reassert after cycle 5 with u=16, s=-9; round_cnt=1. Repeat with both syncs on the same edge → identical result.
- DATA_W=8, S_INIT=-127, S_STEP=-2 → one s transfer gives -128 with S_SAT=1 and 127 with S_SAT=0. U_INIT=254, U_STEP=3 → one u transfer gives u=1.
- Assert rst while s_out_notify=1 in SEC_B → outputs return to reset values asynchronously and round_cnt=0. After release, the first u transfer shows 13.

Source files
------------

// File: rtl/dual_blocking_out_gen.sv
// rtl/dual_blocking_out_gen.sv - two-channel sync/notify producer of running unsigned and signed values
// Alternating (A then B) or parallel section sequencing, with wrap or saturate on the signed path.
module dual_blocking_out_gen #(
    parameter int DATA_W   = 32,
    parameter int U_INIT   = 13,
    parameter int S_INIT   = -7,
    parameter int U_STEP   = 3,
    parameter int S_STEP   = -2,
    parameter bit S_SAT    = 1'b0,
    parameter bit PAR_MODE = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic        [DATA_W-1:0] u_out,
    input  logic                     u_out_sync,
    output logic                     u_out_notify,
    output logic signed [DATA_W-1:0] s_out,
    input  logic                     s_out_sync,
    output logic                     s_out_notify,
    output logic        [1:0]        section_o,
    output logic        [CNT_W-1:0]  round_cnt
);

    typedef enum logic [1:0] {
        SEC_A  = 2'd0,
        SEC_B  = 2'd1,
        SEC_AB = 2'd2
    } sec_e;

    localparam logic [DATA_W-1:0] U_INIT_V = DATA_W'(U_INIT);
    localparam logic [DATA_W-1:0] S_INIT_V = DATA_W'(S_INIT);
    localparam logic [DATA_W-1:0] U_STEP_V = DATA_W'(U_STEP);
    localparam logic [DATA_W:0]   S_STEP_X = (DATA_W+1)'(S_STEP);
    localparam logic [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
    // In alternate mode the signed channel is idle at reset, so its data starts at zero.
    localparam logic [DATA_W-1:0] S_OUT_RST = PAR_MODE ? S_INIT_V : '0;

    sec_e              sec_q, sec_d;
    logic [DATA_W-1:0] u_acc_q, u_acc_d;
    logic [DATA_W-1:0] s_acc_q, s_acc_d;
    logic [DATA_W-1:0] u_out_q, u_out_d;
    logic [DATA_W-1:0] s_out_q, s_out_d;
    logic              u_notify_q, u_notify_d;
    logic              s_notify_q, s_notify_d;
    logic              u_done_q, u_done_d;
    logic              s_done_q, s_done_d;
    logic [CNT_W-1:0]  round_q, round_d;

    logic [DATA_W-1:0] u_next;
    logic [DATA_W:0]   s_sum;
    logic [DATA_W-1:0] s_next;
    logic              u_xfer;
    logic              s_xfer;

    always_comb begin
        u_xfer = u_notify_q & u_out_sync;
        s_xfer = s_notify_q & s_out_sync;
        u_next = u_acc_q + U_STEP_V;
        // Sign-extended sum; the top two bits disagree exactly on signed overflow.
        s_sum  = {s_acc_q[DATA_W-1], s_acc_q} + S_STEP_X;
        if (S_SAT && (s_sum[DATA_W] != s_sum[DATA_W-1])) begin
            s_next = s_sum[DATA_W] ? S_MIN : S_MAX;
        end else begin
            s_next = s_sum[DATA_W-1:0];
        end

        sec_d      = sec_q;
        u_acc_d    = u_acc_q;
        s_acc_d    = s_acc_q;
        u_out_d    = u_out_q;
        s_out_d    = s_out_q;
        u_notify_d = u_notify_q;
        s_notify_d = s_notify_q;
        u_done_d   = u_done_q;
        s_done_d   = s_done_q;
        round_d    = round_q;

        case (sec_q)
            SEC_A: begin
                if (u_xfer) begin
                    u_notify_d = 1'b0;
                    u_acc_d    = u_next;
                    s_out_d    = s_acc_q;
                    s_notify_d = 1'b1;
                    sec_d      = SEC_B;
                end
            end
            SEC_B: begin
                if (s_xfer) begin
                    s_notify_d = 1'b0;
                    s_acc_d    = s_next;
                    u_out_d    = u_acc_q;
                    u_notify_d = 1'b1;
                    round_d    = round_q + CNT_W'(1);
                    sec_d      = SEC_A;
                end
            end
            default: begin
                if (u_xfer) begin
                    u_notify_d = 1'b0;
                    u_acc_d    = u_next;
                    u_done_d   = 1'b1;
                end
                if (s_xfer) begin
                    s_notify_d = 1'b0;
                    s_acc_d    = s_next;
                    s_done_d   = 1'b1;
                end
                // Round closes when both channels have been taken, in either order or together.
                if ((u_done_q | u_xfer) && (s_done_q | s_xfer)) begin
                    u_notify_d = 1'b1;
                    s_notify_d = 1'b1;
                    u_out_d    = u_acc_d;
                    s_out_d    = s_acc_d;
                    u_done_d   = 1'b0;
                    s_done_d   = 1'b0;
                    round_d    = round_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (PAR_MODE) begin
                sec_q <= SEC_AB;
            end else begin
                sec_q <= SEC_A;
            end
            u_acc_q    <= U_INIT_V;
            s_acc_q    <= S_INIT_V;
            u_out_q    <= U_INIT_V;
            s_out_q    <= S_OUT_RST;
            u_notify_q <= 1'b1;
            s_notify_q <= PAR_MODE;
            u_done_q   <= 1'b0;
            s_done_q   <= 1'b0;
            round_q    <= '0;
        end else begin
            sec_q      <= sec_d;
            u_acc_q    <= u_acc_d;
            s_acc_q    <= s_acc_d;
            u_out_q    <= u_out_d;
            s_out_q    <= s_out_d;
            u_notify_q <= u_notify_d;
            s_notify_q <= s_notify_d;
            u_done_q   <= u_done_d;
            s_done_q   <= s_done_d;
            round_q    <= round_d;
        end
    end

    assign u_out        = u_out_q;
    assign s_out        = s_out_q;
    assign u_out_notify = u_notify_q;
    assign s_out_notify = s_notify_q;
    assign section_o    = sec_q;
    assign round_cnt    = round_q;

endmodule
